// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access controller with req/ack port
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        byteword,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        bw_q;
    logic [1:0]  lane_q;
    logic [31:0] ld_data_q;
    logic        ld_valid_q;
    logic        misalign_q;
    logic        bus_err_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;

    logic        access;
    logic        illegal;
    logic        word_misaligned;
    logic [7:0]  lane_byte;
    logic [31:0] load_value;

    assign access          = memread ^ memwrite;
    assign illegal         = memread & memwrite;
    assign word_misaligned = byteword & (addr[1:0] != 2'b00);

    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0: lane_byte = mem_rdata[7:0];
            2'd1: lane_byte = mem_rdata[15:8];
            2'd2: lane_byte = mem_rdata[23:16];
            2'd3: lane_byte = mem_rdata[31:24];
            default: lane_byte = mem_rdata[7:0];
        endcase
        load_value = bw_q ? mem_rdata : {{24{lane_byte[7]}}, lane_byte};
    end

    // Stall must reach the earlier stages in the same cycle the access is seen.
    assign stall = reset & ((state_q == ST_WAIT) |
                            ((state_q == ST_IDLE) & access & ~word_misaligned));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            bw_q        <= 1'b0;
            lane_q      <= 2'd0;
            ld_data_q   <= 32'd0;
            ld_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (illegal) begin
                        bus_err_q <= 1'b1;
                    end else if (access) begin
                        if (word_misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= memwrite;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= byteword ? 4'hF : 4'(4'b0001 << addr[1:0]);
                            mem_wdata_q <= byteword ? wdata : {4{wdata[7:0]}};
                            bw_q        <= byteword;
                            lane_q      <= addr[1:0];
                            cnt_q       <= 8'd0;
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the final timeout cycle still completes the access.
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_RESP;
                        if (!mem_we_q) begin
                            ld_data_q  <= load_value;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        ld_data_q <= 32'd0;
                        cnt_q     <= cnt_q + 8'd1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_data   = ld_data_q;
    assign ld_valid  = ld_valid_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed-vector bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic        byteword;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vec = 0;
    int err = 0;

    int          o_stall;
    int          o_req;
    int          o_ldv;
    logic [31:0] o_ld;
    logic [31:0] o_ldf;
    int          o_berr;
    int          o_mis;
    logic        o_we;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wd;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .byteword(byteword), .addr(addr), .wdata(wdata), .stall(stall),
        .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Presents one instruction, holds it while stalled, acks in cycle ack_at (T = 0), records what it saw.
    task automatic run(input logic rd, input logic wr, input logic bw, input logic [31:0] a,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] rdat);
        logic prev_stall;
        o_stall = 0; o_req = 0; o_ldv = 0; o_ld = 32'h0; o_berr = 0; o_mis = 0;
        o_we = 1'b0; o_addr = 32'h0; o_be = 4'h0; o_wd = 32'h0;
        @(negedge clk);
        memread = rd; memwrite = wr; byteword = bw; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = rdat;
        #1;
        prev_stall = stall;
        if (stall) o_stall++;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (!prev_stall) begin memread = 1'b0; memwrite = 1'b0; end
            mem_ack = (c == ack_at);
            #1;
            if (stall) o_stall++;
            if (mem_req) begin
                o_req++; o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wd = mem_wdata;
            end
            if (ld_valid) begin o_ldv++; o_ld = ld_data; end
            if (bus_err) o_berr++;
            if (misalign) o_mis++;
            prev_stall = stall;
        end
        mem_ack = 1'b0;
        o_ldf = ld_data;
    endtask

    task automatic test_reset;
        reset = 1'b0; memread = 1'b1; memwrite = 1'b0; byteword = 1'b1; addr = 32'h100;
        wdata = 32'hFFFF_FFFF; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++; if (stall !== 1'b0) begin err++; $display("FAIL reset_stall got %b want 0", stall); end
        vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin err++; $display("FAIL reset_req got %b%b want 00", mem_req, mem_we); end
        vec++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin err++; $display("FAIL reset_bus got %h/%h/%h want 0", mem_addr, mem_be, mem_wdata); end
        vec++; if ({ld_data, ld_valid, misalign, bus_err} !== 35'h0) begin err++; $display("FAIL reset_flags got %h %b%b%b want 0", ld_data, ld_valid, misalign, bus_err); end
        memread = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_load_word;
        run(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        vec++; if (o_stall !== 4) begin err++; $display("FAIL ldw_stall got %0d want 4", o_stall); end
        vec++; if (o_req !== 3) begin err++; $display("FAIL ldw_req got %0d want 3", o_req); end
        vec++; if (o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin err++; $display("FAIL ldw_fields got %h %h %b want 100 f 0", o_addr, o_be, o_we); end
        vec++; if (o_ldv !== 1 || o_ld !== 32'hDEAD_BEEF) begin err++; $display("FAIL ldw_data got %0d %h want 1 deadbeef", o_ldv, o_ld); end
        vec++; if (o_berr !== 0 || o_mis !== 0) begin err++; $display("FAIL ldw_flags got %0d %0d want 0 0", o_berr, o_mis); end
    endtask

    task automatic test_load_byte;
        run(1'b1, 1'b0, 1'b0, 32'h203, 32'h0, 1, 32'h80FF_0000);
        vec++; if (o_addr !== 32'h200 || o_be !== 4'b1000) begin err++; $display("FAIL ldb3_fields got %h %b want 200 1000", o_addr, o_be); end
        vec++; if (o_ldv !== 1 || o_ld !== 32'hFFFF_FF80) begin err++; $display("FAIL ldb3_data got %0d %h want 1 ffffff80", o_ldv, o_ld); end
        run(1'b1, 1'b0, 1'b0, 32'h201, 32'h0, 2, 32'h80FF_0000);
        vec++; if (o_be !== 4'b0010 || o_ld !== 32'h0000_0000 || o_ldv !== 1) begin err++; $display("FAIL ldb1 got %b %h %0d want 0010 00000000 1", o_be, o_ld, o_ldv); end
        run(1'b1, 1'b0, 1'b0, 32'h202, 32'h0, 1, 32'h80FF_0000);
        vec++; if (o_be !== 4'b0100 || o_ld !== 32'hFFFF_FFFF) begin err++; $display("FAIL ldb2 got %b %h want 0100 ffffffff", o_be, o_ld); end
    endtask

    task automatic test_store_byte;
        run(1'b0, 1'b1, 1'b0, 32'h32, 32'h1234_5678, 1, 32'h0);
        vec++; if (o_we !== 1'b1 || o_be !== 4'b0100 || o_addr !== 32'h30) begin err++; $display("FAIL stb_fields got %b %b %h want 1 0100 30", o_we, o_be, o_addr); end
        vec++; if (o_wd !== 32'h7878_7878) begin err++; $display("FAIL stb_wdata got %h want 78787878", o_wd); end
        vec++; if (o_stall !== 2 || o_ldv !== 0) begin err++; $display("FAIL stb_stall got %0d ldv %0d want 2 0", o_stall, o_ldv); end
        run(1'b0, 1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 1, 32'h0);
        vec++; if (o_be !== 4'hF || o_wd !== 32'hCAFE_F00D || o_we !== 1'b1) begin err++; $display("FAIL stw got %h %h %b want f cafef00d 1", o_be, o_wd, o_we); end
    endtask

    task automatic test_errors;
        run(1'b0, 1'b1, 1'b1, 32'h06, 32'h1, 1, 32'h0);
        vec++; if (o_mis !== 1 || o_req !== 0 || o_stall !== 0) begin err++; $display("FAIL misalign got mis %0d req %0d stall %0d want 1 0 0", o_mis, o_req, o_stall); end
        run(1'b1, 1'b1, 1'b1, 32'h08, 32'h1, 1, 32'h0);
        vec++; if (o_berr !== 1 || o_req !== 0 || o_stall !== 0) begin err++; $display("FAIL illegal got berr %0d req %0d stall %0d want 1 0 0", o_berr, o_req, o_stall); end
    endtask

    task automatic test_timeout;
        run(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5, 32'h5555_AAAA);
        vec++; if (o_req !== 4) begin err++; $display("FAIL to_req got %0d want 4", o_req); end
        vec++; if (o_berr !== 1 || o_ldv !== 0) begin err++; $display("FAIL to_flags got berr %0d ldv %0d want 1 0", o_berr, o_ldv); end
        vec++; if (o_ldf !== 32'h0 || o_stall !== 5) begin err++; $display("FAIL to_result got %h stall %0d want 0 5", o_ldf, o_stall); end
        run(1'b1, 1'b0, 1'b1, 32'h404, 32'h0, 4, 32'h1357_9BDF);
        vec++; if (o_berr !== 0 || o_ldv !== 1 || o_ld !== 32'h1357_9BDF || o_req !== 4) begin err++; $display("FAIL ack_wins got berr %0d ldv %0d %h req %0d want 0 1 13579bdf 4", o_berr, o_ldv, o_ld, o_req); end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        memread = 1'b1; memwrite = 1'b0; byteword = 1'b1; addr = 32'h40; mem_ack = 1'b0;
        @(negedge clk);
        vec++; if (mem_req !== 1'b1) begin err++; $display("FAIL rw_req1 got %b want 1", mem_req); end
        @(negedge clk);
        reset = 1'b0; memread = 1'b0;
        @(negedge clk);
        vec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin err++; $display("FAIL rw_drop got req %b stall %b want 0 0", mem_req, stall); end
        reset = 1'b1;
        run(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 2, 32'h0BAD_F00D);
        vec++; if (o_ldv !== 1 || o_ld !== 32'h0BAD_F00D || o_stall !== 3) begin err++; $display("FAIL rw_after got %0d %h stall %0d want 1 0badf00d 3", o_ldv, o_ld, o_stall); end
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_load_byte;
        test_store_byte;
        test_errors;
        test_timeout;
        test_reset_in_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
